// File: rtl/ddr_cmd_sched.sv
// ---------------------------------------------------------------------------
// ddr_cmd_sched
//
// Read-side consumer of the DDR controller request FIFO. It pops one request
// at a time and runs a closed-page command sequence ACT -> RD/WR -> PRE. A
// periodic REF is slotted in between requests and never pre-empts one.
//
// Ports
//   rclk       FIFO read-domain clock, all logic on posedge
//   rrst       synchronous active-high reset
//   empty      FIFO empty flag
//   fifo_data  FIFO data_out {we, bank, row, col}, valid the cycle after a pop
//   r_en       one-cycle FIFO pop strobe
//   cmd        NOP=0 ACT=1 RD=2 WR=3 PRE=4 REF=5
//   cmd_bank   bank for ACT/RD/WR/PRE, 0 otherwise
//   cmd_addr   row on ACT, zero-extended column on RD/WR, 0 otherwise
//   busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module ddr_cmd_sched #(
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int REQ_W  = 1 + BA_W + ROW_W + COL_W,
  parameter int T_RCD  = 3,
  parameter int T_RTP  = 2,
  parameter int T_WR   = 4,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 20,
  parameter int T_REFI = 780
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             empty,
  input  logic [REQ_W-1:0] fifo_data,
  output logic             r_en,
  output logic [2:0]       cmd,
  output logic [BA_W-1:0]  cmd_bank,
  output logic [ROW_W-1:0] cmd_addr,
  output logic             busy
);

  localparam int T_M1  = (T_RCD > T_RTP) ? T_RCD : T_RTP;
  localparam int T_M2  = (T_M1 > T_WR) ? T_M1 : T_WR;
  localparam int T_M3  = (T_M2 > T_RP) ? T_M2 : T_RP;
  localparam int T_MAX = (T_M3 > T_RFC) ? T_M3 : T_RFC;
  localparam int WCW   = $clog2(T_MAX) + 1;
  localparam int RFW   = $clog2(T_REFI) + 1;

  // Wait counters are loaded with (cycles - 1) and the state is left when the
  // counter reads zero, so a wait of T-1 cycles loads T-2.
  localparam logic [WCW-1:0] RCD_LD = WCW'(T_RCD - 2);
  localparam logic [WCW-1:0] RTP_LD = WCW'((T_RTP >= 2) ? T_RTP - 2 : 0);
  localparam logic [WCW-1:0] WR_LD  = WCW'((T_WR >= 2) ? T_WR - 2 : 0);
  localparam logic [WCW-1:0] RP_LD  = WCW'(T_RP - 2);
  localparam logic [WCW-1:0] RFC_LD = WCW'(T_RFC - 2);
  // A one-cycle RD->PRE or WR->PRE gap means the W_RW wait is empty.
  localparam bit RTP_SKIP = (T_RTP < 2);
  localparam bit WR_SKIP  = (T_WR < 2);
  localparam logic [RFW-1:0] REFI_LAST = RFW'(T_REFI - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ACT, S_W_RCD, S_RW,
    S_W_RW, S_PRE, S_W_RP, S_REF, S_W_RFC
  } state_t;

  state_t             state_reg;
  logic               req_we_reg;
  logic [BA_W-1:0]    req_bank_reg;
  logic [COL_W-1:0]   req_col_reg;
  logic [WCW-1:0]     wcnt_reg;
  logic [RFW-1:0]     refi_reg;
  logic               ref_pend_reg;
  logic               r_en_reg;
  logic [2:0]         cmd_reg;
  logic [BA_W-1:0]    cmd_bank_reg;
  logic [ROW_W-1:0]   cmd_addr_reg;
  logic               busy_reg;

  logic               refi_wrap;
  logic [RFW-1:0]     refi_next;
  logic               wcnt_zero;
  logic [WCW-1:0]     wcnt_next;
  logic [BA_W-1:0]    fd_bank;
  logic [ROW_W-1:0]   fd_row;
  logic [ROW_W-1:0]   req_col_ext;

  assign refi_wrap   = (refi_reg == REFI_LAST);
  assign refi_next   = refi_wrap ? '0 : refi_reg + RFW'(1);
  assign wcnt_zero   = (wcnt_reg == '0);
  assign wcnt_next   = wcnt_reg - WCW'(1);
  assign fd_bank     = fifo_data[COL_W+ROW_W +: BA_W];
  assign fd_row      = fifo_data[COL_W +: ROW_W];
  assign req_col_ext = ROW_W'(req_col_reg);

  assign r_en     = r_en_reg;
  assign cmd      = cmd_reg;
  assign cmd_bank = cmd_bank_reg;
  assign cmd_addr = cmd_addr_reg;
  assign busy     = busy_reg;

  // Outputs are registered alongside the state: each branch drives the
  // command belonging to the state being entered.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_reg    <= S_IDLE;
      req_we_reg   <= 1'b0;
      req_bank_reg <= '0;
      req_col_reg  <= '0;
      wcnt_reg     <= '0;
      refi_reg     <= '0;
      ref_pend_reg <= 1'b0;
      r_en_reg     <= 1'b0;
      cmd_reg      <= CMD_NOP;
      cmd_bank_reg <= '0;
      cmd_addr_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      refi_reg <= refi_next;
      // Taking the refresh clears the flag; a wrap landing while the flag is
      // still set is absorbed rather than queued.
      if (state_reg == S_IDLE && ref_pend_reg)
        ref_pend_reg <= 1'b0;
      else if (refi_wrap)
        ref_pend_reg <= 1'b1;

      r_en_reg     <= 1'b0;
      cmd_reg      <= CMD_NOP;
      cmd_bank_reg <= '0;
      cmd_addr_reg <= '0;
      busy_reg     <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (ref_pend_reg) begin
            state_reg <= S_REF;
            cmd_reg   <= CMD_REF;
          end else if (!empty) begin
            state_reg <= S_FETCH;
            r_en_reg  <= 1'b1;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        S_FETCH: state_reg <= S_LATCH;
        S_LATCH: begin
          req_we_reg   <= fifo_data[REQ_W-1];
          req_bank_reg <= fd_bank;
          req_col_reg  <= fifo_data[COL_W-1:0];
          state_reg    <= S_ACT;
          cmd_reg      <= CMD_ACT;
          cmd_bank_reg <= fd_bank;
          cmd_addr_reg <= fd_row;
        end
        S_ACT: begin
          state_reg <= S_W_RCD;
          wcnt_reg  <= RCD_LD;
        end
        S_W_RCD: begin
          if (wcnt_zero) begin
            state_reg    <= S_RW;
            cmd_reg      <= req_we_reg ? CMD_WR : CMD_RD;
            cmd_bank_reg <= req_bank_reg;
            cmd_addr_reg <= req_col_ext;
          end else begin
            wcnt_reg <= wcnt_next;
          end
        end
        S_RW: begin
          if (req_we_reg ? WR_SKIP : RTP_SKIP) begin
            state_reg    <= S_PRE;
            cmd_reg      <= CMD_PRE;
            cmd_bank_reg <= req_bank_reg;
          end else begin
            state_reg <= S_W_RW;
            wcnt_reg  <= req_we_reg ? WR_LD : RTP_LD;
          end
        end
        S_W_RW: begin
          if (wcnt_zero) begin
            state_reg    <= S_PRE;
            cmd_reg      <= CMD_PRE;
            cmd_bank_reg <= req_bank_reg;
          end else begin
            wcnt_reg <= wcnt_next;
          end
        end
        S_PRE: begin
          state_reg <= S_W_RP;
          wcnt_reg  <= RP_LD;
        end
        S_W_RP: begin
          if (wcnt_zero) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            wcnt_reg <= wcnt_next;
          end
        end
        S_REF: begin
          state_reg <= S_W_RFC;
          wcnt_reg  <= RFC_LD;
        end
        S_W_RFC: begin
          if (wcnt_zero) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            wcnt_reg <= wcnt_next;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
